alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_arbiter_alu.sv | 58 +++++
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU arbiter slice.
//   alu_op_t    - 3-bit ALU opcode, with named opcode constants
//   alu_flags_t - 4-bit ALU flag vector {negative, zero, carry, overflow}
//   state_t     - arbiter FSM states IDLE / EXEC / RESP
//   FLAGS_W     - flag vector width
package alu_pkg;

  localparam int FLAGS_W = 4;

  typedef logic [2:0]         alu_op_t;
  typedef logic [FLAGS_W-1:0] alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam alu_op_t OP_ADD  = 3'd0;
  localparam alu_op_t OP_SUB  = 3'd1;
  localparam alu_op_t OP_AND  = 3'd2;
  localparam alu_op_t OP_OR   = 3'd3;
  localparam alu_op_t OP_XOR  = 3'd4;
  localparam alu_op_t OP_SLT  = 3'd5;
  localparam alu_op_t OP_SLTU = 3'd6;
  localparam alu_op_t OP_NOR  = 3'd7;

endpackage

// File: rtl/alu_arbiter_alu.sv
// ALU: purely combinational N-bit ALU used by alu_arbiter.
// Ports:
//   a_i, b_i  - N-bit operands
//   op_i      - opcode (ADD, SUB, AND, OR, XOR, SLT signed, SLTU, NOR)
//   result_o  - N-bit result
//   ALUFlags  - {negative, zero, carry, overflow}; carry/overflow are only
//               produced by ADD/SUB, 0 for every other opcode. On SUB the
//               carry is the "no borrow" flag (a >= b unsigned).
module ALU
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       a_i,
  input  logic [N-1:0]       b_i,
  input  logic [2:0]         op_i,
  output logic [N-1:0]       result_o,
  output logic [FLAGS_W-1:0] ALUFlags
);

  logic              is_sub;
  logic [N-1:0]      b_eff;
  logic [N:0]        sum_ext;
  logic signed [N-1:0] a_s;
  logic signed [N-1:0] b_s;
  logic              carry;
  logic              overflow;

  assign is_sub  = (op_i == OP_SUB);
  assign b_eff   = is_sub ? ~b_i : b_i;
  // Subtraction as a + ~b + 1 so one adder serves both ops.
  assign sum_ext = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
  assign a_s     = a_i;
  assign b_s     = b_i;

  always_comb begin
    result_o = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        result_o = sum_ext[N-1:0];
        carry    = sum_ext[N];
        overflow = (a_i[N-1] == b_eff[N-1]) && (sum_ext[N-1] != a_i[N-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLT:  result_o = {{(N-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: result_o = {{(N-1){1'b0}}, (a_i < b_i)};
      OP_NOR:  result_o = ~(a_i | b_i);
      default: result_o = '0;
    endcase
  end

  assign ALUFlags = {result_o[N-1], (result_o == '0), carry, overflow};

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through an IDLE/EXEC/RESP FSM.
// Ports:
//   clk_i, rst_n_i        - clock, synchronous active-low reset
//   req_valid_i[1:0]      - per-requester request
//   req_ready_o[1:0]      - per-requester accept (one-hot or zero, IDLE only)
//   a0_i/b0_i/op0_i       - requester 0 operands and opcode
//   a1_i/b1_i/op1_i       - requester 1 operands and opcode
//   rsp_valid_o           - response held in RESP until rsp_ready_i
//   rsp_ready_i           - consumer accept (ignored outside RESP)
//   rsp_id_o              - requester owning the response
//   rsp_result_o          - registered ALU result
//   rsp_flags_o           - registered ALU flags
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
// wins ties) and removes the round-robin pointer; default is round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [N-1:0]       a0_i,
  input  logic [N-1:0]       b0_i,
  input  logic [2:0]         op0_i,
  input  logic [N-1:0]       a1_i,
  input  logic [N-1:0]       b1_i,
  input  logic [2:0]         op1_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_id_o,
  output logic [N-1:0]       rsp_result_o,
  output logic [FLAGS_W-1:0] rsp_flags_o
);

  state_t     state;
  state_t     state_next;
  logic       grant_id;
  logic       accept;

  logic [N-1:0] a_p0;
  logic [N-1:0] b_p0;
  alu_op_t      op_p0;
  logic         id_p0;

  logic [N-1:0] alu_result;
  alu_flags_t   alu_flags;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_id = ~req_valid_i[0];
  end
`else
  logic last_grant;

  // On a tie, alternate away from the previous winner; a lone request
  // is granted directly without consulting the pointer.
  always_comb begin
    grant_id = 1'b0;
    if (&req_valid_i) grant_id = ~last_grant;
    else              grant_id = req_valid_i[1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)    last_grant <= 1'b1;
    else if (accept) last_grant <= grant_id;
  end
`endif

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    req_ready_o = 2'b00;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        // Ready is suppressed while reset is held so nothing can transfer.
        if (rst_n_i && (|req_valid_i)) begin
          accept      = 1'b1;
          req_ready_o = grant_id ? 2'b10 : 2'b01;
          state_next  = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // Stage p0: capture the granted requester's operands at acceptance.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_p0  <= grant_id ? a1_i  : a0_i;
      b_p0  <= grant_id ? b1_i  : b0_i;
      op_p0 <= grant_id ? op1_i : op0_i;
      id_p0 <= grant_id;
    end
  end

  ALU #(.N(N)) u_alu (
    .a_i      (a_p0),
    .b_i      (b_p0),
    .op_i     (op_p0),
    .result_o (alu_result),
    .ALUFlags (alu_flags)
  );

  // Stage p1: register the ALU output; held untouched through RESP.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rsp_id_o     <= 1'b0;
      rsp_result_o <= '0;
      rsp_flags_o  <= '0;
    end else if (state == EXEC) begin
      rsp_id_o     <= id_p0;
      rsp_result_o <= alu_result;
      rsp_flags_o  <= alu_flags;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] a0, b0, a1, b1;
  logic [2:0]   op0, op1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  int   tests_run = 0;
  int   fails     = 0;
  logic exp_last  = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .a0_i         (a0),
    .b0_i         (b0),
    .op0_i        (op0),
    .a1_i         (a1),
    .b1_i         (b1),
    .op1_i        (op1),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_flags_o  (rsp_flags)
  );

  // Reference ALU from the opcode table, using integer arithmetic.
  // Returns {N, Z, C, V, result}.
  function automatic logic [N+3:0] alu_ref(input int a, input int b, input int op);
    int lim  = 1 << N;
    int half = 1 << (N - 1);
    int sa, sb, r;
    bit c = 0, v = 0;
    logic [N-1:0] rb;
    sa = (a >= half) ? a - lim : a;
    sb = (b >= half) ? b - lim : b;
    case (op)
      0: begin r = a + b; c = (r >= lim); v = (sa + sb >= half) || (sa + sb < -half); end
      1: begin r = a - b + lim; c = (a >= b); v = (sa - sb >= half) || (sa - sb < -half); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = (a < b) ? 1 : 0;
      default: r = ~(a | b);
    endcase
    r  = r & (lim - 1);
    rb = r[N-1:0];
    return {rb[N-1], (rb == 0), c, v, rb};
  endfunction

  // Grant rule: lone request wins; a tie goes to whoever did not win last
  // (or always requester 0 with fixed priority).
  function automatic logic exp_grant(input logic [1:0] v);
    logic g;
    if (v == 2'b01)      g = 1'b0;
    else if (v == 2'b10) g = 1'b1;
    else begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = (exp_last == 1'b1) ? 1'b0 : 1'b1;
`endif
    end
    return g;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_last = 1'b1;
  endtask

  // Issue one request and collect its response (no checks here).
  task automatic run_txn(input logic [1:0] vmask, input bit early_rdy, input int hold,
                         output logic [1:0] rdy, output int lat, output logic id,
                         output logic [N-1:0] res, output logic [3:0] flg);
    @(negedge clk);
    req_valid = vmask; rsp_ready = 1'b0;
    #1 rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 2'b00;
    if (early_rdy) rsp_ready = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; break; end
    end
    id = rsp_id; res = rsp_result; flg = rsp_flags;
    if (lat != 0) begin
      if (!early_rdy) begin
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests_run++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    tests_run++; if (rsp_result !== '0) begin fails++; $display("FAIL reset_result got=%b exp=0", rsp_result); end
    tests_run++; if (rsp_flags !== 4'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0", rsp_flags); end
    tests_run++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_id got=%b exp=0", rsp_id); end
    req_valid = 2'b00; rsp_ready = 1'b0; rst_n = 1'b1;
    exp_last = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0] rdy; int lat; logic id; logic [N-1:0] res; logic [3:0] flg;
    logic [N+3:0] e;
    a0 = 4'b1010; b0 = 4'b1100; op0 = 3'b010;
    a1 = 4'($urandom); b1 = 4'($urandom); op1 = 3'($urandom);
    e = alu_ref(a0, b0, op0);
    run_txn(2'b01, 1'b1, 0, rdy, lat, id, res, flg);
    exp_last = 1'b0;
    tests_run++; if (rdy !== 2'b01) begin fails++; $display("FAIL single_ready got=%b exp=01", rdy); end
    tests_run++; if (lat !== 2) begin fails++; $display("FAIL single_latency got=%0d exp=2", lat); end
    tests_run++; if (id !== 1'b0) begin fails++; $display("FAIL single_id got=%b exp=0", id); end
    tests_run++; if (res !== e[N-1:0]) begin fails++; $display("FAIL single_result got=%b exp=%b", res, e[N-1:0]); end
    tests_run++; if (flg !== e[N+3:N]) begin fails++; $display("FAIL single_flags got=%b exp=%b", flg, e[N+3:N]); end
  endtask

  task automatic test_random();
    logic [1:0] rdy, vm; int lat; logic id, eg; logic [N-1:0] res; logic [3:0] flg;
    logic [N+3:0] e;
    for (int k = 0; k < 16; k++) begin
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom_range(0, 7));
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 3'($urandom_range(0, 7));
      vm = 2'($urandom_range(1, 3));
      eg = exp_grant(vm);
      e  = eg ? alu_ref(a1, b1, op1) : alu_ref(a0, b0, op0);
      run_txn(vm, 1'($urandom_range(0, 1)), $urandom_range(0, 2), rdy, lat, id, res, flg);
      exp_last = eg;
      tests_run++; if (rdy !== (eg ? 2'b10 : 2'b01)) begin fails++; $display("FAIL rand_ready[%0d] got=%b grant=%b", k, rdy, eg); end
      tests_run++; if (lat !== 2) begin fails++; $display("FAIL rand_latency[%0d] got=%0d exp=2", k, lat); end
      tests_run++; if (id !== eg) begin fails++; $display("FAIL rand_id[%0d] got=%b exp=%b", k, id, eg); end
      tests_run++; if ({flg, res} !== e) begin fails++; $display("FAIL rand_rsp[%0d] got=%b exp=%b", k, {flg, res}, e); end
    end
  endtask

  task automatic test_contention();
    logic [1:0] rdy; int lat; logic id, eg; logic [N-1:0] res; logic [3:0] flg;
    logic [N+3:0] e;
    do_reset();
    a1 = 4'b1111; b1 = 4'b0000; op1 = 3'b011;
    a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom);
    for (int k = 0; k < 4; k++) begin
      eg = exp_grant(2'b11);
      e  = eg ? alu_ref(a1, b1, op1) : alu_ref(a0, b0, op0);
      run_txn(2'b11, 1'b1, 0, rdy, lat, id, res, flg);
      exp_last = eg;
      tests_run++; if (rdy !== (eg ? 2'b10 : 2'b01)) begin fails++; $display("FAIL contend_ready[%0d] got=%b grant=%b", k, rdy, eg); end
      tests_run++; if (id !== eg) begin fails++; $display("FAIL contend_id[%0d] got=%b exp=%b", k, id, eg); end
      tests_run++; if ({flg, res} !== e) begin fails++; $display("FAIL contend_rsp[%0d] got=%b exp=%b", k, {flg, res}, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [N+3:0] e;
    bit seen = 0;
    a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom);
    e = alu_ref(a0, b0, op0);
    @(negedge clk);
    req_valid = 2'b01; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 2'b00;
    exp_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    tests_run++; if (!seen) begin fails++; $display("FAIL bp_response got=none exp=rsp_valid"); end
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); end
      tests_run++; if ({rsp_flags, rsp_result} !== e) begin fails++; $display("FAIL bp_rsp[%0d] got=%b exp=%b", i, {rsp_flags, rsp_result}, e); end
      tests_run++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL bp_id[%0d] got=%b exp=0", i, rsp_id); end
      tests_run++; if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_req_ready[%0d] got=%b exp=00", i, req_ready); end
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
    req_valid = 2'b10;
    #1;
    tests_run++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_idle_ready got=%b exp=10", req_ready); end
    req_valid = 2'b00;
  endtask

  task automatic test_operand_change();
    logic [N+3:0] e;
    bit seen = 0;
    a0 = 4'b1110; b0 = 4'b1000; op0 = 3'b111;
    e = alu_ref(4'b1110, 4'b1000, 3'b111);
    @(negedge clk);
    req_valid = 2'b01; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 2'b00;
    a0 = 4'b0000; b0 = 4'($urandom); op0 = 3'b000;
    exp_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    tests_run++; if (!seen) begin fails++; $display("FAIL opchg_response got=none exp=rsp_valid"); end
    tests_run++; if ({rsp_flags, rsp_result} !== e) begin fails++; $display("FAIL opchg_rsp got=%b exp=%b", {rsp_flags, rsp_result}, e); end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_midop_reset();
    logic [1:0] rdy; int lat; logic id; logic [N-1:0] res; logic [3:0] flg;
    logic [N+3:0] e;
    bit spurious = 0;
    do_reset();
    a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom);
    a1 = 4'($urandom); b1 = 4'($urandom); op1 = 3'($urandom);
    @(negedge clk);
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin fails++; $display("FAIL midrst_first_grant got=%b exp=01", req_ready); end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests_run++; if (req_ready !== 2'b00) begin fails++; $display("FAIL midrst_ready_in_reset got=%b exp=00", req_ready); end
    req_valid = 2'b00; rst_n = 1'b1;
    exp_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) spurious = 1;
    end
    tests_run++; if (spurious) begin fails++; $display("FAIL midrst_no_response got=rsp_valid exp=none"); end
    tests_run++; if (rsp_result !== '0) begin fails++; $display("FAIL midrst_result got=%b exp=0", rsp_result); end
    rsp_ready = 1'b0;
    e = alu_ref(a0, b0, op0);
    run_txn(2'b11, 1'b0, 1, rdy, lat, id, res, flg);
    exp_last = 1'b0;
    tests_run++; if (rdy !== 2'b01) begin fails++; $display("FAIL midrst_tie_grant got=%b exp=01", rdy); end
    tests_run++; if ({flg, res} !== e) begin fails++; $display("FAIL midrst_rsp got=%b exp=%b", {flg, res}, e); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
    test_reset();
    test_single();
    test_random();
    test_contention();
    test_backpressure();
    test_operand_change();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
